// File: rtl/spi_target_if.sv
// SPI pin bundle between an external host (master) and spi_target (slave).
interface spi_target_if;
  logic SPI_SS;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic SPI_MISO;
  logic SPI_MISO_OE;

  modport master (
    output SPI_SS,
    output SPI_SCK,
    output SPI_MOSI,
    input  SPI_MISO,
    input  SPI_MISO_OE
  );

  modport slave (
    input  SPI_SS,
    input  SPI_SCK,
    input  SPI_MOSI,
    output SPI_MISO,
    output SPI_MISO_OE
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 responder exposing a bank of 2^ADDR_BITS 8-bit registers to an external host.
// Define SPI_TARGET_AUTOINC_EN to advance the address pointer after every data byte.
module spi_target #(
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic                 CLK1,
  input  logic                 RST,
  spi_target_if.slave          spi,
  input  logic [ADDR_BITS-1:0] LOC_RADDR,
  output logic [7:0]           LOC_RDATA,
  input  logic                 LOC_WE,
  input  logic [ADDR_BITS-1:0] LOC_WADDR,
  input  logic [7:0]           LOC_WDATA,
  output logic                 WR_STROBE,
  output logic [ADDR_BITS-1:0] WR_ADDR,
  output logic                 BUSY
);

  localparam int unsigned NumRegs = 2 ** ADDR_BITS;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic ss_s1_q, ss_s2_q, ss_prev_q;
  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [1:0]           state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           rx_q, rx_d;
  logic [7:0]           tx_q, tx_d;
  logic                 wr_dir_q, wr_dir_d;
  logic                 load_q, load_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] ptr_step;
  logic                 strobe_q, strobe_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           regs_q [NumRegs];
  logic [7:0]           regs_d [NumRegs];

  logic       ss_fall, sck_rise, sck_fall, host_we, busy;
  logic [7:0] byte_in;

  // SS flops reset low so a frame only starts after SS is genuinely seen high then low.
  assign ss_fall  = ss_prev_q & ~ss_s2_q;
  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;
  assign byte_in  = {rx_q[6:0], mosi_s2_q};
  assign busy     = ~ss_s2_q & ((state_q != StIdle) | ss_fall);

`ifdef SPI_TARGET_AUTOINC_EN
  assign ptr_step = ptr_q + ADDR_BITS'(1);
`else
  assign ptr_step = ptr_q;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    wr_dir_d  = wr_dir_q;
    load_d    = load_q;
    ptr_d     = ptr_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    host_we   = 1'b0;

    if (state_q == StIdle) begin
      bit_cnt_d = '0;
      tx_d      = '0;
      load_d    = 1'b0;
      if (ss_fall) begin
        state_d = StCmd;
      end
    end else if (ss_s2_q) begin
      // Deselect: drop any partial byte and pending load.
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_d      = '0;
      load_d    = 1'b0;
    end else begin
      if (sck_rise) begin
        rx_d      = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == StCmd) begin
            wr_dir_d = byte_in[7];
            ptr_d    = byte_in[ADDR_BITS-1:0];
            load_d   = ~byte_in[7];
            state_d  = StData;
          end else if (wr_dir_q) begin
            host_we   = 1'b1;
            strobe_d  = 1'b1;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_step;
          end else begin
            load_d = 1'b1;
          end
        end
      end
      if (sck_fall) begin
        if (load_q) begin
          tx_d   = regs_q[ptr_q];
          ptr_d  = ptr_step;
          load_d = 1'b0;
        end else if (state_q == StData && !wr_dir_q) begin
          tx_d = {tx_q[6:0], 1'b0};
        end else begin
          tx_d = '0;
        end
      end
    end
  end

  // Host write is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (LOC_WE) begin
      regs_d[LOC_WADDR] = LOC_WDATA;
    end
    if (host_we) begin
      regs_d[ptr_q] = byte_in;
    end
  end

  always_ff @(posedge CLK1) begin
    if (RST) begin
      ss_s1_q    <= 1'b0;
      ss_s2_q    <= 1'b0;
      ss_prev_q  <= 1'b0;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      wr_dir_q   <= 1'b0;
      load_q     <= 1'b0;
      ptr_q      <= '0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      regs_q     <= '{default: '0};
    end else begin
      ss_s1_q    <= spi.SPI_SS;
      ss_s2_q    <= ss_s1_q;
      ss_prev_q  <= ss_s2_q;
      sck_s1_q   <= spi.SPI_SCK;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= spi.SPI_MOSI;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      wr_dir_q   <= wr_dir_d;
      load_q     <= load_d;
      ptr_q      <= ptr_d;
      strobe_q   <= strobe_d;
      wr_addr_q  <= wr_addr_d;
      regs_q     <= regs_d;
    end
  end

  assign spi.SPI_MISO    = tx_q[7];
  assign spi.SPI_MISO_OE = busy;
  assign BUSY            = busy;
  assign LOC_RDATA       = regs_q[LOC_RADDR];
  assign WR_STROBE       = strobe_q;
  assign WR_ADDR         = wr_addr_q;

endmodule

// File: tb/tb_spi_target.sv
// Randomized self-checking bench for spi_target against a frame-level register-bank model.
module tb_spi_target;

  localparam int AB = 3;
  localparam int NR = 8;
`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          CLK1 = 1'b0;
  logic          RST = 1'b1;
  logic [AB-1:0] LOC_RADDR = '0;
  logic [7:0]    LOC_RDATA;
  logic          LOC_WE = 1'b0;
  logic [AB-1:0] LOC_WADDR = '0;
  logic [7:0]    LOC_WDATA = '0;
  logic          WR_STROBE;
  logic [AB-1:0] WR_ADDR;
  logic          BUSY;

  spi_target_if sif ();

  spi_target #(.ADDR_BITS(AB)) dut (
    .CLK1      (CLK1),
    .RST       (RST),
    .spi       (sif),
    .LOC_RADDR (LOC_RADDR),
    .LOC_RDATA (LOC_RDATA),
    .LOC_WE    (LOC_WE),
    .LOC_WADDR (LOC_WADDR),
    .LOC_WDATA (LOC_WDATA),
    .WR_STROBE (WR_STROBE),
    .WR_ADDR   (WR_ADDR),
    .BUSY      (BUSY)
  );

  always #5 CLK1 = ~CLK1;

  int n_checks = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  bit chk_en = 1'b0;

  // Frame-level model: register bank plus where the host is within its frame.
  logic [7:0]    m_regs [NR];
  bit            m_active, m_first, m_write;
  logic [AB-1:0] m_ptr;
  logic          exp_strobe = 1'b0;
  logic          exp_busy = 1'b0;
  logic [AB-1:0] exp_wr_addr = '0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK1) begin
    if (chk_en) begin
      check8("rdata", LOC_RDATA, m_regs[LOC_RADDR]);
      check8("wr_strobe", {7'd0, WR_STROBE}, {7'd0, exp_strobe});
      check8("wr_addr", {5'd0, WR_ADDR}, {5'd0, exp_wr_addr});
      check8("busy", {7'd0, BUSY}, {7'd0, exp_busy});
      check8("miso_oe", {7'd0, sif.SPI_MISO_OE}, {7'd0, exp_busy});
    end
  end

  always @(posedge CLK1) begin
    if (WR_STROBE === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK1);
    #1;
    LOC_RADDR = AB'($urandom);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_active    = 1'b0;
    m_first     = 1'b0;
    m_write     = 1'b0;
    m_ptr       = '0;
    exp_strobe  = 1'b0;
    exp_busy    = 1'b0;
    exp_wr_addr = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_active) return;
    if (m_first) begin
      m_first = 1'b0;
      m_write = b[7];
      m_ptr   = b[AB-1:0];
    end else begin
      if (m_write) begin
        m_regs[m_ptr] = b;
        exp_strobe    = 1'b1;
        exp_wr_addr   = m_ptr;
      end
      if (AUTOINC) m_ptr = m_ptr + 3'd1;
    end
  endtask

  task automatic ss_low();
    repeat (4) tick();
    sif.SPI_SS = 1'b0;
    m_active = 1'b1;
    m_first  = 1'b1;
    tick();
    tick();
    exp_busy = 1'b1;
    tick();
    tick();
  endtask

  task automatic ss_high();
    repeat (4) tick();
    sif.SPI_SS = 1'b1;
    m_active = 1'b0;
    tick();
    tick();
    exp_busy = 1'b0;
    repeat (4) tick();
    check8("miso_idle", {7'd0, sif.SPI_MISO}, 8'h00);
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_clear();
  endtask

  // Shift nbits of b (MSB first); optional local write lands in the same cycle as a byte commit.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit loc_en,
                      input logic [AB-1:0] la, input logic [7:0] ld, output logic [7:0] mb);
    logic [7:0] exp_b;
    exp_b = (m_active && !m_first && !m_write) ? m_regs[m_ptr] : 8'h00;
    mb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sif.SPI_MOSI = b[7-i];
      repeat (4) tick();
      mb[7-i] = sif.SPI_MISO;
      sif.SPI_SCK = 1'b1;
      if (i == 7) begin
        tick();
        tick();
        if (loc_en) begin
          LOC_WE    = 1'b1;
          LOC_WADDR = la;
          LOC_WDATA = ld;
        end
        tick();
        LOC_WE = 1'b0;
        if (loc_en) m_regs[la] = ld;
        model_byte(b);
        tick();
        exp_strobe = 1'b0;
      end else begin
        repeat (4) tick();
      end
      sif.SPI_SCK = 1'b0;
    end
    if (nbits == 8) check8("miso_byte", mb, exp_b);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] mb;
    xfer(b, 8, 1'b0, '0, 8'h00, mb);
  endtask

  task automatic loc_write(input logic [AB-1:0] a, input logic [7:0] d);
    LOC_WE    = 1'b1;
    LOC_WADDR = a;
    LOC_WDATA = d;
    tick();
    LOC_WE = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic chk_reg(input string name, input logic [AB-1:0] a, input logic [7:0] exp);
    LOC_RADDR = a;
    #1;
    check8(name, LOC_RDATA, exp);
  endtask

  initial begin
    logic [7:0] mb0, mb1;
    int cnt0;
    sif.SPI_SS   = 1'b1;
    sif.SPI_SCK  = 1'b0;
    sif.SPI_MOSI = 1'b0;
    model_clear();
    repeat (3) tick();
    RST = 1'b0;
    chk_en = 1'b1;
    check8("rst_busy", {7'd0, BUSY}, 8'h00);
    check8("rst_oe", {7'd0, sif.SPI_MISO_OE}, 8'h00);
    check8("rst_miso", {7'd0, sif.SPI_MISO}, 8'h00);
    check8("rst_wr_addr", {5'd0, WR_ADDR}, 8'h00);
    chk_reg("rst_reg5", 3'd5, 8'h00);

    // Frame 0x82 0xA5 0x3C
    ss_low();
    send(8'h82);
    send(8'hA5);
    send(8'h3C);
    ss_high();
    check8("t1_strobes", 8'(strobe_cnt), 8'd2);
    check8("t1_wr_addr", {5'd0, WR_ADDR}, AUTOINC ? 8'h03 : 8'h02);
    chk_reg("t1_reg2", 3'd2, AUTOINC ? 8'hA5 : 8'h3C);
    chk_reg("t1_reg3", 3'd3, AUTOINC ? 8'h3C : 8'h00);

    // Local write then host read of reg5
    loc_write(3'd5, 8'h96);
    ss_low();
    xfer(8'h05, 8, 1'b0, '0, 8'h00, mb0);
    xfer(8'h00, 8, 1'b0, '0, 8'h00, mb1);
    ss_high();
    check8("t2_cmd_miso", mb0, 8'h00);
    check8("t2_data_miso", mb1, 8'h96);
    check8("t2_strobes", 8'(strobe_cnt), 8'd2);

    // Pointer wrap 7 -> 0
    ss_low();
    send(8'h87);
    send(8'h11);
    send(8'h22);
    ss_high();
    chk_reg("t3_reg7", 3'd7, AUTOINC ? 8'h11 : 8'h22);
    chk_reg("t3_reg0", 3'd0, AUTOINC ? 8'h22 : 8'h00);

    // Abort after 5 bits of a data byte
    ss_low();
    send(8'h81);
    xfer(8'hFF, 5, 1'b0, '0, 8'h00, mb0);
    ss_high();
    chk_reg("t4_reg1_abort", 3'd1, 8'h00);
    check8("t4_strobes", 8'(strobe_cnt), 8'd4);
    ss_low();
    send(8'h81);
    send(8'h55);
    ss_high();
    chk_reg("t4_reg1", 3'd1, 8'h55);
    check8("t4_strobes2", 8'(strobe_cnt), 8'd5);

    // Same-cycle collisions
    ss_low();
    send(8'h84);
    xfer(8'h77, 8, 1'b1, 3'd4, 8'h11, mb0);
    ss_high();
    chk_reg("t5_reg4", 3'd4, 8'h77);
    ss_low();
    send(8'h86);
    xfer(8'h33, 8, 1'b1, 3'd1, 8'h44, mb0);
    ss_high();
    chk_reg("t5_reg6", 3'd6, 8'h33);
    chk_reg("t5_reg1", 3'd1, 8'h44);

    // Reset mid-frame with SS held low and SCK still running
    ss_low();
    send(8'h83);
    xfer(8'hFF, 4, 1'b0, '0, 8'h00, mb0);
    rst_pulse();
    cnt0 = strobe_cnt;
    send(8'h83);
    send(8'hAA);
    check8("t6_busy", {7'd0, BUSY}, 8'h00);
    check8("t6_oe", {7'd0, sif.SPI_MISO_OE}, 8'h00);
    chk_reg("t6_reg3", 3'd3, 8'h00);
    chk_reg("t6_reg4", 3'd4, 8'h00);
    check8("t6_strobes", 8'(strobe_cnt - cnt0), 8'd0);
    ss_high();
    ss_low();
    send(8'h80);
    send(8'hEE);
    ss_high();
    chk_reg("t6_reg0", 3'd0, 8'hEE);

    // Randomized frames
    for (int f = 0; f < 120; f++) begin
      int nloc, nb;
      nloc = $urandom_range(0, 2);
      for (int k = 0; k < nloc; k++) loc_write(AB'($urandom), 8'($urandom));
      ss_low();
      send(8'($urandom));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        int nbits;
        nbits = (k == nb - 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
        xfer(8'($urandom), nbits, ($urandom_range(0, 2) == 0), AB'($urandom),
             8'($urandom), mb0);
      end
      if ($urandom_range(0, 14) == 0) begin
        rst_pulse();
        send(8'($urandom));
      end
      ss_high();
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
